alu_op_decode_stage: RTL

//  Producing end of the execute-stage ALU interface: decodes a MIPS-I instruction from ID into

---
 rtl/alu_op_decode_stage.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_op_decode_stage.sv
`default_nettype none
//==============================================================================
// Module      : alu_op_decode_stage
// Description : Decodes a MIPS-I instruction into ALU op/operands and holds it,
//               with destination info, in a one-entry ID/EX valid/ready slot.
//               Optional feature macro: ALU_DEC_OVF_EN (adds ovfChkE output).
// Revision    : 1.0 - initial release
//==============================================================================

`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef ALU_OP_LENGTH
`define ALU_OP_LENGTH 4
`endif
`ifndef ALU_AND
`define ALU_AND      4'd0
`define ALU_OR       4'd1
`define ALU_ADD      4'd2
`define ALU_XOR      4'd3
`define ALU_NOR      4'd4
`define ALU_SUB      4'd6
`define ALU_SLT      4'd7
`define ALU_SLTU     4'd8
`define ALU_LS_LEFT  4'd9
`define ALU_LS_RIGHT 4'd10
`define ALU_AS_RIGHT 4'd11
`define ALU_LUI      4'd12
`endif

module alu_op_decode_stage (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      validD,
    output logic                      readyD,
    input  logic [31:0]               instrD,
    input  logic [`WORD_WIDTH-1:0]    rsDataD,
    input  logic [`WORD_WIDTH-1:0]    rtDataD,
    input  logic                      flushE,
    output logic                      validE,
    input  logic                      readyE,
    output logic [`ALU_OP_LENGTH-1:0] aluOpE,
    output logic [`WORD_WIDTH-1:0]    SrcA,
    output logic [`WORD_WIDTH-1:0]    SrcB,
    output logic [4:0]                writeRegE,
    output logic                      regWriteE,
    output logic                      illegalE
`ifdef ALU_DEC_OVF_EN
    ,
    output logic                      ovfChkE
`endif
);

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_full = 1'b1;

    localparam logic [5:0] c_opc_rtype = 6'h00;
    localparam logic [5:0] c_opc_addi  = 6'h08;
    localparam logic [5:0] c_opc_addiu = 6'h09;
    localparam logic [5:0] c_opc_slti  = 6'h0A;
    localparam logic [5:0] c_opc_sltiu = 6'h0B;
    localparam logic [5:0] c_opc_andi  = 6'h0C;
    localparam logic [5:0] c_opc_ori   = 6'h0D;
    localparam logic [5:0] c_opc_xori  = 6'h0E;
    localparam logic [5:0] c_opc_lui   = 6'h0F;
    localparam logic [5:0] c_opc_lw    = 6'h23;
    localparam logic [5:0] c_opc_sw    = 6'h2B;

    localparam logic [5:0] c_fn_sll  = 6'h00;
    localparam logic [5:0] c_fn_srl  = 6'h02;
    localparam logic [5:0] c_fn_sra  = 6'h03;
    localparam logic [5:0] c_fn_sllv = 6'h04;
    localparam logic [5:0] c_fn_srlv = 6'h06;
    localparam logic [5:0] c_fn_srav = 6'h07;
    localparam logic [5:0] c_fn_add  = 6'h20;
    localparam logic [5:0] c_fn_addu = 6'h21;
    localparam logic [5:0] c_fn_sub  = 6'h22;
    localparam logic [5:0] c_fn_subu = 6'h23;
    localparam logic [5:0] c_fn_and  = 6'h24;
    localparam logic [5:0] c_fn_or   = 6'h25;
    localparam logic [5:0] c_fn_xor  = 6'h26;
    localparam logic [5:0] c_fn_nor  = 6'h27;
    localparam logic [5:0] c_fn_slt  = 6'h2A;
    localparam logic [5:0] c_fn_sltu = 6'h2B;

    localparam int c_ww = `WORD_WIDTH;

    // Instruction fields
    logic [5:0]  w_opcode;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [4:0]  w_shamt;
    logic [5:0]  w_funct;
    logic [15:0] w_imm;
    logic [c_ww-1:0] w_imm_sext;
    logic [c_ww-1:0] w_imm_zext;
    logic [c_ww-1:0] w_shamt_ext;

    assign w_opcode    = instrD[31:26];
    assign w_rt        = instrD[20:16];
    assign w_rd        = instrD[15:11];
    assign w_shamt     = instrD[10:6];
    assign w_funct     = instrD[5:0];
    assign w_imm       = instrD[15:0];
    assign w_imm_sext  = {{(c_ww-16){w_imm[15]}}, w_imm};
    assign w_imm_zext  = {{(c_ww-16){1'b0}}, w_imm};
    assign w_shamt_ext = {{(c_ww-5){1'b0}}, w_shamt};

    // Decoder outputs
    logic [`ALU_OP_LENGTH-1:0] w_op;
    logic [c_ww-1:0]           w_src_a;
    logic [c_ww-1:0]           w_src_b;
    logic [4:0]                w_dst;
    logic                      w_store;
    logic                      w_illegal;
    logic                      w_ovf;
    logic                      w_reg_write;
    logic [4:0]                w_write_reg;

    always_comb begin
        w_op      = `ALU_AND;
        w_src_a   = rsDataD;
        w_src_b   = rtDataD;
        w_dst     = w_rt;
        w_store   = 1'b0;
        w_illegal = 1'b0;
        w_ovf     = 1'b0;
        case (w_opcode)
            c_opc_rtype: begin
                w_dst = w_rd;
                case (w_funct)
                    c_fn_add:  begin w_op = `ALU_ADD; w_ovf = 1'b1; end
                    c_fn_addu: w_op = `ALU_ADD;
                    c_fn_sub:  begin w_op = `ALU_SUB; w_ovf = 1'b1; end
                    c_fn_subu: w_op = `ALU_SUB;
                    c_fn_and:  w_op = `ALU_AND;
                    c_fn_or:   w_op = `ALU_OR;
                    c_fn_xor:  w_op = `ALU_XOR;
                    c_fn_nor:  w_op = `ALU_NOR;
                    c_fn_slt:  w_op = `ALU_SLT;
                    c_fn_sltu: w_op = `ALU_SLTU;
                    c_fn_sll:  begin w_op = `ALU_LS_LEFT;  w_src_a = w_shamt_ext; end
                    c_fn_srl:  begin w_op = `ALU_LS_RIGHT; w_src_a = w_shamt_ext; end
                    c_fn_sra:  begin w_op = `ALU_AS_RIGHT; w_src_a = w_shamt_ext; end
                    c_fn_sllv: w_op = `ALU_LS_LEFT;
                    c_fn_srlv: w_op = `ALU_LS_RIGHT;
                    c_fn_srav: w_op = `ALU_AS_RIGHT;
                    default:   w_illegal = 1'b1;
                endcase
            end
            c_opc_addi:  begin w_op = `ALU_ADD;  w_src_b = w_imm_sext; w_ovf = 1'b1; end
            c_opc_addiu: begin w_op = `ALU_ADD;  w_src_b = w_imm_sext; end
            c_opc_lw:    begin w_op = `ALU_ADD;  w_src_b = w_imm_sext; end
            c_opc_sw:    begin w_op = `ALU_ADD;  w_src_b = w_imm_sext; w_store = 1'b1; end
            c_opc_slti:  begin w_op = `ALU_SLT;  w_src_b = w_imm_sext; end
            c_opc_sltiu: begin w_op = `ALU_SLTU; w_src_b = w_imm_sext; end
            c_opc_andi:  begin w_op = `ALU_AND;  w_src_b = w_imm_zext; end
            c_opc_ori:   begin w_op = `ALU_OR;   w_src_b = w_imm_zext; end
            c_opc_xori:  begin w_op = `ALU_XOR;  w_src_b = w_imm_zext; end
            c_opc_lui: begin
                w_op    = `ALU_LUI;
                w_src_a = w_imm_zext;
                w_src_b = '0;
            end
            default: w_illegal = 1'b1;
        endcase

        // Illegal instructions degrade to a harmless AND of zeros
        if (w_illegal) begin
            w_op    = `ALU_AND;
            w_src_a = '0;
            w_src_b = '0;
            w_ovf   = 1'b0;
        end

        w_reg_write = !w_illegal && !w_store && (w_dst != 5'd0);
        w_write_reg = w_reg_write ? w_dst : 5'd0;
    end

    // Handshake
    logic [0:0] r_state;
    logic [0:0] w_state_nxt;
    logic       w_load;

    assign readyD = !validE || readyE;
    assign w_load = validD && readyD && !flushE;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_load) w_state_nxt = c_st_full;
            end
            c_st_full: begin
                if (w_load)                w_state_nxt = c_st_full;
                else if (readyE || flushE) w_state_nxt = c_st_idle;
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    always_comb begin
        validE = (r_state == c_st_full);
    end

    // Slot payload only changes on an accepted load, so stalls hold it
    logic [`ALU_OP_LENGTH-1:0] r_op;
    logic [c_ww-1:0]           r_src_a;
    logic [c_ww-1:0]           r_src_b;
    logic [4:0]                r_write_reg;
    logic                      r_reg_write;
    logic                      r_illegal;
    logic                      r_ovf;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op        <= '0;
            r_src_a     <= '0;
            r_src_b     <= '0;
            r_write_reg <= '0;
            r_reg_write <= 1'b0;
            r_illegal   <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (w_load) begin
            r_op        <= w_op;
            r_src_a     <= w_src_a;
            r_src_b     <= w_src_b;
            r_write_reg <= w_write_reg;
            r_reg_write <= w_reg_write;
            r_illegal   <= w_illegal;
            r_ovf       <= w_ovf;
        end
    end

    assign aluOpE    = r_op;
    assign SrcA      = r_src_a;
    assign SrcB      = r_src_b;
    assign writeRegE = r_write_reg;
    assign regWriteE = r_reg_write;
    assign illegalE  = r_illegal;

`ifdef ALU_DEC_OVF_EN
    assign ovfChkE = r_ovf;
    logic w_unused;
    assign w_unused = ^instrD[25:21];
`else
    logic w_unused;
    assign w_unused = ^{instrD[25:21], r_ovf};
`endif

endmodule

`default_nettype wire
